i2c_init_sequencer: RTL

//  Walks a table of I2C register writes and feeds them one at a time to the single-write I2C master.

---
 rtl/i2c_init_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_init_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_init_sequencer
//
// Walks a table of I2C register writes (synchronous ROM) and hands them one at
// a time to a single-write I2C master. Each table entry is
// {dev_id[6:0], reg_id[7:0], data[7:0]}; dev_id == 7'h7F ends the run early.
// Used at power-up to configure external peripherals. The host starts a run
// with go and polls busy/done/error.
//
// Optional feature macro:
//   I2C_SEQ_GAP_EN  - when defined, GAP_CYCLES idle cycles are inserted between
//                     consecutive writes (slow-slave recovery). When undefined
//                     the gap state and its counter are not built.
//
// Ports:
//   clk         in   system clock (also the I2C master clock)
//   reset_n     in   asynchronous active-low reset
//   go          in   start a run; sampled only in IDLE/DONE
//   tbl_addr    out  table read address (ADDR_W bits)
//   tbl_entry   in   table word, valid one cycle after tbl_addr
//   i2c_start   out  start request to the I2C master
//   i2c_dev_id  out  7-bit device address of the current write
//   i2c_reg_id  out  register index of the current write
//   i2c_data    out  data byte of the current write
//   i2c_ready   in   master idle indication
//   busy        out  high while a run is in progress
//   done        out  sticky run-finished flag, cleared by the next accepted go
//   error       out  sticky busy-timeout flag, cleared by the next accepted go
//   wr_count    out  writes completed in the current/last run (ADDR_W+1 bits)
// -----------------------------------------------------------------------------
module i2c_init_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int NUM_ENTRIES = 16,
  parameter int BUSY_TO     = 64,
  parameter int GAP_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [22:0]       tbl_entry,
  output logic              i2c_start,
  output logic [6:0]        i2c_dev_id,
  output logic [7:0]        i2c_reg_id,
  output logic [7:0]        i2c_data,
  input  logic              i2c_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   wr_count
);

  localparam int TMR_W = $clog2(BUSY_TO + 1);

  if (NUM_ENTRIES < 1 || NUM_ENTRIES > (2 ** ADDR_W) || BUSY_TO < 2 || GAP_CYCLES < 1) begin : g_param_check
    $error("i2c_init_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_RD   = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
`ifdef I2C_SEQ_GAP_EN
    S_GAP       = 3'd6,
`endif
    S_DONE      = 3'd7
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W:0]   wr_count_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic              done_reg;
  logic              error_reg;
  logic [6:0]        dev_id_reg;
  logic [7:0]        reg_id_reg;
  logic [7:0]        data_reg;

`ifdef I2C_SEQ_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  logic [GAP_W-1:0]  gap_cnt_reg;
`endif

  logic last_entry;
  logic busy_timeout;

  assign last_entry   = (idx_reg == ADDR_W'(NUM_ENTRIES - 1));
  assign busy_timeout = (timer_reg == TMR_W'(BUSY_TO - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (go) state_next = S_FETCH;
      end
      S_FETCH:   state_next = S_WAIT_RD;
      S_WAIT_RD: begin
        if (tbl_entry[22:16] == 7'h7F) state_next = S_DONE;
        else                           state_next = S_ISSUE;
      end
      S_ISSUE:   state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        // ready low wins over an expiring timer on the same cycle
        if (!i2c_ready)        state_next = S_WAIT_DONE;
        else if (busy_timeout) state_next = S_DONE;
      end
      S_WAIT_DONE: begin
        if (i2c_ready) begin
          if (last_entry) state_next = S_DONE;
`ifdef I2C_SEQ_GAP_EN
          else            state_next = S_GAP;
`else
          else            state_next = S_FETCH;
`endif
        end
      end
`ifdef I2C_SEQ_GAP_EN
      S_GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) state_next = S_FETCH;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
    // Start is requested from ISSUE until the master drops ready; decoding it
    // from state lets an asynchronous reset drop it immediately.
    i2c_start = (state_reg == S_ISSUE) || (state_reg == S_WAIT_BUSY);
  end

  // Datapath: index, counters, sticky flags and the held write fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_reg      <= '0;
      wr_count_reg <= '0;
      timer_reg    <= '0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      dev_id_reg   <= '0;
      reg_id_reg   <= '0;
      data_reg     <= '0;
`ifdef I2C_SEQ_GAP_EN
      gap_cnt_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (go) begin
            idx_reg      <= '0;
            wr_count_reg <= '0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
          end
        end
        S_WAIT_RD: begin
          dev_id_reg <= tbl_entry[22:16];
          reg_id_reg <= tbl_entry[15:8];
          data_reg   <= tbl_entry[7:0];
          timer_reg  <= '0;
        end
        S_ISSUE: begin
          // timer counts cycles with start high, ISSUE being cycle 0
          timer_reg <= timer_reg + TMR_W'(1);
        end
        S_WAIT_BUSY: begin
          if (i2c_ready && busy_timeout) error_reg <= 1'b1;
          else                           timer_reg <= timer_reg + TMR_W'(1);
        end
        S_WAIT_DONE: begin
          if (i2c_ready) begin
            wr_count_reg <= wr_count_reg + (ADDR_W + 1)'(1);
            idx_reg      <= idx_reg + ADDR_W'(1);
          end
`ifdef I2C_SEQ_GAP_EN
          gap_cnt_reg <= '0;
`endif
        end
`ifdef I2C_SEQ_GAP_EN
        S_GAP: begin
          gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
        end
`endif
        default: ;
      endcase
      if (state_next == S_DONE) done_reg <= 1'b1;
    end
  end

  // idx is a register, so the ROM sees the address throughout FETCH and its
  // word is on tbl_entry during WAIT_RD.
  assign tbl_addr   = idx_reg;
  assign i2c_dev_id = dev_id_reg;
  assign i2c_reg_id = reg_id_reg;
  assign i2c_data   = data_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign wr_count   = wr_count_reg;

endmodule
